// File: rtl/arx_hash_pkg.sv
// ----------------------------------------------------------------------------
// arx_hash_pkg
// Shared definitions for the ARX chaining hash core:
//   - state_t      : controller states (IDLE, ROUND, OUT)
//   - IV_TABLE     : 8-entry initial chaining value table (32-bit words)
//   - GOLDEN_RATIO : multiplier used to derive the per-round constants
//   - rotl()       : left-rotate of a word held in the low 'width' bits
// ----------------------------------------------------------------------------
package arx_hash_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        OUT   = 2'd2
    } state_t;

    localparam logic [31:0] IV_TABLE [8] = '{
        32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
        32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19
    };

    localparam logic [31:0] GOLDEN_RATIO = 32'h9E3779B9;

    // Rotates the low 'width' bits of 'word' left by 'amt'; bits above
    // 'width' are returned as zero. 'amt' must lie in 1..width-1.
    function automatic logic [31:0] rotl(
        input logic [31:0] word,
        input int unsigned amt,
        input int unsigned width
    );
        logic [31:0] mask;
        logic [31:0] w;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        w    = word & mask;
        return ((w << amt) | (w >> (width - amt))) & mask;
    endfunction

endpackage

// File: rtl/arx_chain_hash_if.sv
// ----------------------------------------------------------------------------
// arx_chain_hash_if
// Block input stream and digest output stream of the ARX chaining hash.
//   in_valid/in_ready/in_data/in_last : message block stream (word 0 = MSBs)
//   out_valid/out_ready/out_digest     : digest stream (word 0 = MSBs)
//   busy                               : core is mixing or holding a digest
// master = producer/consumer side, slave = hash core.
// ----------------------------------------------------------------------------
interface arx_chain_hash_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
);
    localparam int DATA_W = WORD_W * NUM_WORDS;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_digest;
    logic              busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_digest, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_digest, busy
    );
endinterface

// File: rtl/arx_round.sv
// ----------------------------------------------------------------------------
// arx_round
// One combinational add-rotate-xor round over NUM_WORDS words:
//   v'[i] = rotl(v[i] + (v[i+1] ^ RC[r]), ROT) ^ v[i-1]   (indices mod NUM_WORDS)
//   RC[r] = low WORD_W bits of GOLDEN_RATIO * (r+1) mod 2^32
// Ports:
//   i_v          : current state vector (word 0 = MSBs)
//   i_rc_index   : round number r
//   o_v_next     : state vector after the round
// ----------------------------------------------------------------------------
module arx_round
    import arx_hash_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int ROT       = 7
) (
    input  logic [WORD_W*NUM_WORDS-1:0] i_v,
    input  logic [4:0]                  i_rc_index,
    output logic [WORD_W*NUM_WORDS-1:0] o_v_next
);
    logic [31:0]       w_rc_full;
    logic [WORD_W-1:0] w_rc;

    assign w_rc_full = GOLDEN_RATIO * (32'(i_rc_index) + 32'd1);
    assign w_rc      = w_rc_full[WORD_W-1:0];

    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        // Word gi lives at the (NUM_WORDS-1-gi)-th slot from the LSB end.
        localparam int LSB_CUR = (NUM_WORDS - 1 - gi) * WORD_W;
        localparam int LSB_NXT = (NUM_WORDS - 1 - ((gi + 1) % NUM_WORDS)) * WORD_W;
        localparam int LSB_PRV = (NUM_WORDS - 1 - ((gi + NUM_WORDS - 1) % NUM_WORDS)) * WORD_W;

        logic [WORD_W-1:0] w_cur;
        logic [WORD_W-1:0] w_nxt;
        logic [WORD_W-1:0] w_prv;
        logic [WORD_W-1:0] w_sum;
        logic [31:0]       w_rot;

        assign w_cur = i_v[LSB_CUR +: WORD_W];
        assign w_nxt = i_v[LSB_NXT +: WORD_W];
        assign w_prv = i_v[LSB_PRV +: WORD_W];
        assign w_sum = w_cur + (w_nxt ^ w_rc);
        assign w_rot = rotl(32'(w_sum), ROT, WORD_W);

        assign o_v_next[LSB_CUR +: WORD_W] = w_rot[WORD_W-1:0] ^ w_prv;
    end

endmodule

// File: rtl/arx_chain_hash.sv
// ----------------------------------------------------------------------------
// arx_chain_hash
// Iterative ARX hash core with a chaining state between message blocks.
// A block is XORed into the chain, mixed for ROUNDS cycles (one round per
// clock), then fed forward by wordwise addition into the chain. On the final
// block of a message the new chain is presented as the digest and held until
// the consumer accepts it, after which the chain restarts from the IV.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset
//   s_bus : block/digest streams and busy flag (slave side)
// ----------------------------------------------------------------------------
module arx_chain_hash
    import arx_hash_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int ROUNDS    = 8,
    parameter int ROT       = 7
) (
    input logic           clk,
    input logic           rst,
    arx_chain_hash_if.slave s_bus
);
    localparam int DATA_W = WORD_W * NUM_WORDS;
    localparam int RC_W   = 5;
    localparam logic [RC_W-1:0] LAST_RC = RC_W'(ROUNDS - 1);

    if (WORD_W != 16 && WORD_W != 32) begin : g_bad_word_w
        $error("arx_chain_hash: WORD_W must be 16 or 32");
    end
    if (NUM_WORDS < 2 || NUM_WORDS > 8) begin : g_bad_num_words
        $error("arx_chain_hash: NUM_WORDS must be in 2..8");
    end
    if (ROUNDS < 1 || ROUNDS > 32) begin : g_bad_rounds
        $error("arx_chain_hash: ROUNDS must be in 1..32");
    end
    if (ROT < 1 || ROT > WORD_W - 1) begin : g_bad_rot
        $error("arx_chain_hash: ROT must be in 1..WORD_W-1");
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_chain;
    logic [DATA_W-1:0] r_v;
    logic [RC_W-1:0]   r_rc;
    logic              r_last;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_digest;

    logic [DATA_W-1:0] w_iv;
    logic [DATA_W-1:0] w_v_next;
    logic [DATA_W-1:0] w_chain_ff;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_last_round;
    logic              w_out_hs;

    // IV: first NUM_WORDS table entries, truncated to WORD_W, word 0 at MSBs.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_iv
        assign w_iv[(NUM_WORDS-1-gi)*WORD_W +: WORD_W] = IV_TABLE[gi][WORD_W-1:0];
    end

    arx_round #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS),
        .ROT       (ROT)
    ) u_round (
        .i_v        (r_v),
        .i_rc_index (r_rc),
        .o_v_next   (w_v_next)
    );

    // Feed-forward uses the round output directly so it lands on the same
    // edge as the final round.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_ff
        localparam int LSB = (NUM_WORDS - 1 - gi) * WORD_W;
        assign w_chain_ff[LSB +: WORD_W] = w_v_next[LSB +: WORD_W] + r_chain[LSB +: WORD_W];
    end

    assign w_in_ready   = (r_state == IDLE) && !rst;
    assign w_accept     = s_bus.in_valid && w_in_ready;
    assign w_last_round = (r_state == ROUND) && (r_rc == LAST_RC);
    assign w_out_hs     = (r_state == OUT) && r_out_valid && s_bus.out_ready;

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the default at the top of the block keeps every path assigned, so
    // no latch is inferred for w_state_next.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept)     w_state_next = ROUND;
            ROUND:   if (w_last_round) w_state_next = r_last ? OUT : IDLE;
            OUT:     if (w_out_hs)     w_state_next = IDLE;
            default:                   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain      <= w_iv;
            r_v          <= '0;
            r_rc         <= '0;
            r_last       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_digest <= '0;
        end else begin
            if (w_accept) begin
                r_v    <= r_chain ^ s_bus.in_data;
                r_last <= s_bus.in_last;
                r_rc   <= '0;
            end
            if (r_state == ROUND) begin
                r_v  <= w_v_next;
                r_rc <= r_rc + RC_W'(1);
            end
            if (w_last_round) begin
                r_chain <= w_chain_ff;
                if (r_last) begin
                    r_out_digest <= w_chain_ff;
                    r_out_valid  <= 1'b1;
                end
            end
            // Digest register is deliberately left alone here so the last
            // digest stays visible until the next one replaces it.
            if (w_out_hs) begin
                r_out_valid <= 1'b0;
                r_chain     <= w_iv;
            end
        end
    end

    assign s_bus.in_ready   = w_in_ready;
    assign s_bus.out_valid  = r_out_valid;
    assign s_bus.out_digest = r_out_digest;
    assign s_bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_arx_chain_hash.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_arx_chain_hash
// Directed bench for arx_chain_hash: default configuration (32x4, 8 rounds)
// plus a 16x8, 1-round instance. Expected digests come from a bench-side
// software model of the hash.
// ----------------------------------------------------------------------------
module tb_arx_chain_hash;

    localparam int A_W = 32, A_N = 4, A_R = 8, A_ROT = 7;
    localparam int B_W = 16, B_N = 8, B_R = 1, B_ROT = 7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    arx_chain_hash_if #(.WORD_W(A_W), .NUM_WORDS(A_N)) if_a ();
    arx_chain_hash_if #(.WORD_W(B_W), .NUM_WORDS(B_N)) if_b ();

    arx_chain_hash #(.WORD_W(A_W), .NUM_WORDS(A_N), .ROUNDS(A_R), .ROT(A_ROT)) u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .s_bus (if_a.slave)
    );

    arx_chain_hash #(.WORD_W(B_W), .NUM_WORDS(B_N), .ROUNDS(B_R), .ROT(B_ROT)) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .s_bus (if_b.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Software model: up to two blocks, word 0 at MSBs.
    function automatic logic [127:0] model_hash(
        input int ww, input int nw, input int nr, input int rot,
        input int nblk, input logic [127:0] b0, input logic [127:0] b1
    );
        longint unsigned iv_tab [8];
        longint unsigned ch [8];
        longint unsigned v [8];
        longint unsigned t [8];
        longint unsigned mask, rc, s;
        logic [127:0] blk, res;
        iv_tab = '{64'h6A09E667, 64'hBB67AE85, 64'h3C6EF372, 64'hA54FF53A,
                   64'h510E527F, 64'h9B05688C, 64'h1F83D9AB, 64'h5BE0CD19};
        mask = (64'd1 << ww) - 64'd1;
        for (int i = 0; i < 8; i++) begin
            ch[i] = 0;
            v[i]  = 0;
            t[i]  = 0;
        end
        for (int i = 0; i < nw; i++) ch[i] = iv_tab[i] & mask;
        for (int b = 0; b < nblk; b++) begin
            blk = (b == 0) ? b0 : b1;
            for (int i = 0; i < nw; i++)
                v[i] = ch[i] ^ (64'(blk >> ((nw - 1 - i) * ww)) & mask);
            rc = 0;
            for (int r = 0; r < nr; r++) begin
                rc = (rc + 64'h9E3779B9) & 64'hFFFF_FFFF;   // running multiple of the constant
                for (int i = 0; i < nw; i++) begin
                    s    = (v[i] + (v[(i + 1) % nw] ^ (rc & mask))) & mask;
                    s    = ((s << rot) | (s >> (ww - rot))) & mask;
                    t[i] = s ^ v[(i + nw - 1) % nw];
                end
                for (int i = 0; i < nw; i++) v[i] = t[i];
            end
            for (int i = 0; i < nw; i++) ch[i] = (ch[i] + v[i]) & mask;
        end
        res = '0;
        for (int i = 0; i < nw; i++) res = res | (128'(ch[i]) << ((nw - 1 - i) * ww));
        return res;
    endfunction

    task automatic wait_out_a(input int max_cycles, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < max_cycles) begin
            tick();
            n++;
            seen = if_a.out_valid;
        end
    endtask

    task automatic send_a(input logic [127:0] data, input logic last);
        int guard;
        guard = 0;
        if_a.in_valid = 1'b1;
        if_a.in_data  = data;
        if_a.in_last  = last;
        while (!if_a.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("send_ready_timeout", guard < 50, 1);
        tick();
        if_a.in_valid = 1'b0;
    endtask

    task automatic out_hs_a();
        if_a.out_ready = 1'b1;
        tick();
        if_a.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation time limit expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] c1, c2, d_single, d_two, d_fresh, d_flip, d_b;
        int  n, wait_n;
        bit  seen, found;

        c1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        c2 = c1 ^ (128'd1 << 77);

        rst = 1'b1;
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_last = 1'b0; if_a.out_ready = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_last = 1'b0; if_b.out_ready = 1'b0;

        // ---------------- Reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready_held", if_a.in_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", if_a.in_ready, 1);
        check("rst_out_valid", if_a.out_valid, 0);
        check("rst_out_digest", if_a.out_digest, 0);
        check("rst_busy", if_a.busy, 0);
        check("rst_b_out_valid", if_b.out_valid, 0);

        // ---------------- Single block, latency ----------------
        d_single = model_hash(A_W, A_N, A_R, A_ROT, 1, 128'h0, 128'h0);
        if_a.in_valid = 1'b1;
        if_a.in_data  = '0;
        if_a.in_last  = 1'b1;
        tick();                         // accept edge k
        if_a.in_valid = 1'b0;
        for (int j = 1; j <= A_R; j++) begin
            tick();
            check($sformatf("sb_in_ready_%0d", j), if_a.in_ready, 0);
            check($sformatf("sb_out_valid_%0d", j), if_a.out_valid, (j == A_R) ? 1 : 0);
        end
        check("sb_digest", if_a.out_digest, d_single);
        check("sb_busy_out", if_a.busy, 1);
        out_hs_a();
        check("sb_hs_out_valid", if_a.out_valid, 0);
        check("sb_hs_in_ready", if_a.in_ready, 1);
        check("sb_hs_digest_kept", if_a.out_digest, d_single);

        // ---------------- Two-block message, continuous valid ----------------
        d_two = model_hash(A_W, A_N, A_R, A_ROT, 2, 128'h1, {128{1'b1}});
        if_a.out_ready = 1'b1;          // no digest pending: must have no effect
        if_a.in_valid  = 1'b1;
        if_a.in_data   = 128'h1;
        if_a.in_last   = 1'b0;
        tick();                         // first block accepted
        if_a.in_data   = {128{1'b1}};
        if_a.in_last   = 1'b1;
        wait_n = 0;
        found  = 1'b0;
        while (!found && wait_n < 20) begin
            if (if_a.in_ready) found = 1'b1;
            else begin
                tick();
                wait_n++;
            end
        end
        check("2b_gap_found", found, 1);
        check("2b_gap_cycles", wait_n, A_R);
        tick();                         // second block accepted
        check("2b_ready_one_cycle", if_a.in_ready, 0);
        if_a.in_valid = 1'b0;
        wait_out_a(20, n, seen);
        check("2b_out_seen", seen, 1);
        check("2b_latency", n, A_R);
        check("2b_digest", if_a.out_digest, d_two);
        check("2b_ne_blk0", if_a.out_digest != model_hash(A_W, A_N, A_R, A_ROT, 1, 128'h1, 128'h0), 1);
        check("2b_ne_blk1", if_a.out_digest != model_hash(A_W, A_N, A_R, A_ROT, 1, {128{1'b1}}, 128'h0), 1);
        tick();                         // out_ready still high: handshake
        if_a.out_ready = 1'b0;
        check("2b_hs_out_valid", if_a.out_valid, 0);

        // ---------------- Backpressure, ignored in_valid ----------------
        if_a.in_valid = 1'b1;
        if_a.in_data  = '0;
        if_a.in_last  = 1'b1;
        tick();                         // accepted
        if_a.in_last  = 1'b0;           // junk while busy
        if_a.in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        wait_out_a(20, n, seen);
        check("bp_out_seen", seen, 1);
        check("bp_latency", n, A_R);
        for (int j = 1; j <= 5; j++) begin
            if_a.in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            check($sformatf("bp_digest_%0d", j), if_a.out_digest, d_single);
            check($sformatf("bp_valid_%0d", j), if_a.out_valid, 1);
            check($sformatf("bp_in_ready_%0d", j), if_a.in_ready, 0);
        end
        if_a.in_valid = 1'b0;
        out_hs_a();
        check("bp_hs_out_valid", if_a.out_valid, 0);
        check("bp_hs_in_ready", if_a.in_ready, 1);

        // ---------------- Reset mid-round ----------------
        if_a.in_valid = 1'b1;
        if_a.in_data  = '0;
        if_a.in_last  = 1'b1;
        tick();
        if_a.in_valid = 1'b0;
        repeat (3) tick();              // rounds 0..2 done, round 3 pending
        check("mr_busy_before", if_a.busy, 1);
        rst = 1'b1;
        #1;
        check("mr_in_ready", if_a.in_ready, 0);
        check("mr_busy", if_a.busy, 0);
        check("mr_out_valid", if_a.out_valid, 0);
        check("mr_out_digest", if_a.out_digest, 0);
        tick();
        check("mr_busy_next", if_a.busy, 0);
        check("mr_out_digest_next", if_a.out_digest, 0);
        rst = 1'b0;
        #1;
        d_fresh = model_hash(A_W, A_N, A_R, A_ROT, 1, c1, 128'h0);
        send_a(c1, 1'b1);
        wait_out_a(20, n, seen);
        check("mr_fresh_seen", seen, 1);
        check("mr_fresh_latency", n, A_R);
        check("mr_fresh_digest", if_a.out_digest, d_fresh);
        out_hs_a();

        // ---------------- Avalanche ----------------
        d_flip = model_hash(A_W, A_N, A_R, A_ROT, 1, c2, 128'h0);
        send_a(c2, 1'b1);
        wait_out_a(20, n, seen);
        check("av_seen", seen, 1);
        check("av_digest", if_a.out_digest, d_flip);
        check("av_bits_changed", $countones(if_a.out_digest ^ d_fresh) >= 32, 1);
        out_hs_a();

        // ---------------- 16x8, one round ----------------
        d_b = model_hash(B_W, B_N, B_R, B_ROT, 1, 128'h0, 128'h0);
        check("b_in_ready", if_b.in_ready, 1);
        if_b.in_valid = 1'b1;
        if_b.in_data  = '0;
        if_b.in_last  = 1'b1;
        tick();                         // accept edge k
        if_b.in_valid = 1'b0;
        check("b_busy_round", if_b.busy, 1);
        check("b_out_valid_early", if_b.out_valid, 0);
        tick();                         // edge k+1
        check("b_out_valid", if_b.out_valid, 1);
        check("b_digest", if_b.out_digest, d_b);
        if_b.out_ready = 1'b1;
        tick();
        if_b.out_ready = 1'b0;
        check("b_hs_out_valid", if_b.out_valid, 0);
        check("b_hs_in_ready", if_b.in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
